fifo_uart_tx: RTL and testbench

- Downstream consumer of the 8-bit, 16-deep fifo.
- Drains the fifo one byte at a time and serialises each byte onto an asynchronous UART line: 1 start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
- Sits between the fifo read port and the board-level serial pin.
- Owns the fifo read handshake and never issues a read while the fifo reports empty.

---
 rtl/fifo_uart_tx_if.sv | 10 +
 rtl/fifo_uart_tx.sv | 115 +++++++++++
 tb/tb_fifo_uart_tx.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between a registered-output fifo and its UART transmitter.
// The transmitter is the master: it owns rd_en and consumes empty/dout.
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;

  modport master (input fifo_empty, input fifo_dout, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_dout, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains an 8-bit fifo one byte per frame and serialises it as 8N1/8E1/8O1/8x2 UART.
// tx is decoded from state so an asynchronous reset returns the line high at once.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  fifo_uart_tx_if.master        bus,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           byte_count
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic        ODD_SEL   = (PARITY_ODD != 0);

  state_t      state, state_nxt;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        parity_bit;
  logic        baud_last, bit_last, stop_last;

  assign baud_last      = (baud_cnt == BAUD_LAST);
  assign bit_last       = (bit_cnt == 3'd7);
  assign stop_last      = (bit_cnt == STOP_LAST);
  assign bus.fifo_rd_en = (state == FETCH);
  assign busy           = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_nxt  = state;
    tx         = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (tx_en && !bus.fifo_empty) state_nxt = FETCH;
      FETCH:  state_nxt = LOAD;
      LOAD:   state_nxt = START;
      START: begin
        tx = 1'b0;
        if (baud_last) state_nxt = DATA;
      end
      DATA: begin
        tx = shift_reg[0];
        if (baud_last && bit_last) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        tx = parity_bit;
        if (baud_last) state_nxt = STOP;
      end
      STOP: begin
        if (baud_last && stop_last) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bit_cnt indexes data bits in DATA and stop bits in STOP; it is zero on entry to both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      byte_count <= '0;
    end else begin
      if (frame_done) byte_count <= byte_count + 16'd1;
      case (state)
        LOAD: begin
          shift_reg  <= bus.fifo_dout;
          parity_bit <= (^bus.fifo_dout) ^ ODD_SEL;
          baud_cnt   <= '0;
          bit_cnt    <= '0;
        end
        START, DATA, PARITY, STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (state == DATA) begin
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_last ? 3'd0 : bit_cnt + 3'd1;
            end else if (state == STOP) begin
              bit_cnt   <= stop_last ? 3'd0 : bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Four transmitter lanes (8N1, 8E1, 8O1, 8N2 at 4 clk/bit) fed by identical fifo models;
// each lane is checked every cycle against a waveform expanded from the frame rules.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  typedef struct packed { logic tx; logic rd; logic done; } exp_t;
  typedef struct {
    int         lane;
    logic [7:0] data;
    int         len;
    int         low;
    bit         chk_par;
    logic       par;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, tx_en, wr_en;
  logic [7:0]  wr_data;
  logic [3:0]  tx_w, busy_w, done_w, rd_w, empty_w;
  logic [15:0] cnt_w [4];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam int PEN   = (g == 1 || g == 2) ? 1 : 0;
    localparam int PODD  = (g == 2) ? 1 : 0;
    localparam int NSTOP = (g == 3) ? 2 : 1;

    fifo_uart_tx_if bus ();

    fifo_uart_tx #(
      .CLKS_PER_BIT(CPB), .PARITY_EN(PEN), .PARITY_ODD(PODD), .STOP_BITS(NSTOP)
    ) dut (
      .clk(clk), .reset(reset), .tx_en(tx_en), .bus(bus),
      .tx(tx_w[g]), .busy(busy_w[g]), .frame_done(done_w[g]), .byte_count(cnt_w[g])
    );

    assign rd_w[g]    = bus.fifo_rd_en;
    assign empty_w[g] = bus.fifo_empty;

    logic [7:0]  fq[$];
    exp_t        eq[$];
    logic [15:0] frames = '0;
    int          rdn = 0;

    // Expands one byte into the per-cycle line waveform: FETCH, LOAD, then the frame bits.
    function automatic void push_frame(input logic [7:0] d);
      int          nb;
      logic [11:0] bits;
      nb      = 1 + 8 + PEN + NSTOP;
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = d[i];
      if (PEN != 0) bits[9] = (^d) ^ (PODD != 0);
      eq.push_back('{tx: 1'b1, rd: 1'b1, done: 1'b0});
      eq.push_back('{tx: 1'b1, rd: 1'b0, done: 1'b0});
      for (int k = 0; k < nb; k++)
        for (int c = 0; c < CPB; c++)
          eq.push_back('{tx: bits[k], rd: 1'b0, done: (k == nb - 1 && c == CPB - 1)});
    endfunction

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        eq.delete();
        frames = '0;
        bus.fifo_empty <= (fq.size() == 0);
        bus.fifo_dout  <= '0;
      end else begin
        if (eq.size() != 0) begin
          if (eq[0].done) frames = frames + 16'd1;
          void'(eq.pop_front());
        end else if (tx_en && !bus.fifo_empty) begin
          push_frame(fq[0]);
        end
        if (bus.fifo_rd_en && fq.size() != 0) bus.fifo_dout <= fq.pop_front();
        if (wr_en && fq.size() < 16) fq.push_back(wr_data);
        bus.fifo_empty <= (fq.size() == 0);
      end
    end

    always @(negedge clk) begin
      exp_t e;
      logic busy_e;
      busy_e = (eq.size() != 0);
      if (busy_e) e = eq[0];
      else        e = '{tx: 1'b1, rd: 1'b0, done: 1'b0};
      if (rd_w[g]) rdn++;
      check($sformatf("lane%0d cycle {tx,rd,done,busy,count}", g),
            {12'd0, tx_w[g], rd_w[g], done_w[g], busy_w[g], cnt_w[g]},
            {12'd0, e.tx, e.rd, e.done, busy_e, frames});
    end
  end

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_fall(input int lane, input int limit, output bit ok);
    int t = 0;
    while (tx_w[lane] !== 1'b0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    ok = (t < limit);
  endtask

  task automatic drain(input int limit);
    int t = 0;
    while ((busy_w !== 4'h0 || empty_w !== 4'hF) && t < limit) begin
      @(negedge clk);
      t++;
    end
    check("drain to idle", 32'(t < limit), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int   len, low;
    bit   ok, in_low;
    logic par;
    write_byte(v.data);
    wait_fall(v.lane, 20, ok);
    check($sformatf("vec %02h lane%0d start bit", v.data, v.lane), 32'(ok), 32'd1);
    len    = 0;
    low    = 0;
    in_low = 1'b1;
    par    = 1'b0;
    while (done_w[v.lane] !== 1'b1 && len < 200) begin
      if (in_low && tx_w[v.lane] == 1'b0) low++;
      else in_low = 1'b0;
      if (len == 37) par = tx_w[v.lane];
      len++;
      @(negedge clk);
    end
    len++;
    check($sformatf("vec %02h lane%0d frame length", v.data, v.lane), len, v.len);
    check($sformatf("vec %02h lane%0d leading low run", v.data, v.lane), low, v.low);
    if (v.chk_par)
      check($sformatf("vec %02h lane%0d parity bit", v.data, v.lane), 32'(par), 32'(v.par));
    drain(200);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[10];
    vec_t       v;
    bit         ok;
    int         rbase;
    logic [15:0] base;

    vecs[0] = '{0, 8'hF1, 40,  4, 1'b0, 1'b0};
    vecs[1] = '{1, 8'hF3, 44,  4, 1'b1, 1'b0};
    vecs[2] = '{2, 8'hF3, 44,  4, 1'b1, 1'b1};
    vecs[3] = '{3, 8'h00, 44, 36, 1'b0, 1'b0};
    vecs[4] = '{1, 8'h00, 44, 40, 1'b1, 1'b0};
    vecs[5] = '{2, 8'h00, 44, 36, 1'b1, 1'b1};
    vecs[6] = '{0, 8'hFF, 40,  4, 1'b0, 1'b0};
    vecs[7] = '{3, 8'h80, 44, 32, 1'b0, 1'b0};
    vecs[8] = '{1, 8'h01, 44,  4, 1'b1, 1'b1};
    vecs[9] = '{0, 8'h55, 40,  4, 1'b0, 1'b0};

    reset   = 1'b1;
    tx_en   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    @(negedge clk);
    check("reset tx", 32'(tx_w), 32'hF);
    check("reset busy", 32'(busy_w), 32'h0);
    check("reset byte_count", 32'(cnt_w[0]), 32'h0);

    // Single frames with hand-computed length, low run and parity.
    tx_en = 1'b1;
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    check("table byte_count", 32'(cnt_w[0]), 32'd10);
    check("table rd pulses", g_lane[0].rdn, 32'd10);

    // Burst of 14 bytes queued while blocked, then released.
    tx_en = 1'b0;
    for (int i = 0; i < 14; i++) write_byte(8'hF1 + 8'(i));
    base  = cnt_w[0];
    rbase = g_lane[0].rdn;
    repeat (5) @(negedge clk);
    check("blocked no read", g_lane[0].rdn, rbase);
    check("blocked idle", 32'(busy_w), 32'h0);
    tx_en = 1'b1;
    drain(3000);
    check("burst byte_count", 32'(cnt_w[0]), 32'(base + 16'd14));
    check("burst rd pulses", g_lane[0].rdn, rbase + 14);
    rbase = g_lane[0].rdn;
    repeat (20) @(negedge clk);
    check("empty no read", g_lane[0].rdn, rbase);

    // tx_en dropped during START: current frame finishes, nothing more is fetched.
    tx_en = 1'b0;
    write_byte(8'h3C);
    write_byte(8'hC3);
    write_byte(8'h5A);
    base  = cnt_w[0];
    rbase = g_lane[0].rdn;
    tx_en = 1'b1;
    wait_fall(0, 20, ok);
    check("txen-drop start bit", 32'(ok), 32'd1);
    @(negedge clk);
    tx_en = 1'b0;
    repeat (80) @(negedge clk);
    check("txen-drop one read", g_lane[0].rdn, rbase + 1);
    check("txen-drop one frame", 32'(cnt_w[0]), 32'(base + 16'd1));
    check("txen-drop holds idle", 32'(busy_w), 32'h0);
    tx_en = 1'b1;
    drain(400);
    check("txen-resume reads", g_lane[0].rdn, rbase + 3);
    check("txen-resume frames", 32'(cnt_w[0]), 32'(base + 16'd3));

    // Asynchronous reset in the middle of data bit 3.
    write_byte(8'h0F);
    wait_fall(0, 20, ok);
    check("reset-test start bit", 32'(ok), 32'd1);
    repeat (17) @(negedge clk);
    check("pre-reset busy", 32'(busy_w[0]), 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset tx", 32'(tx_w), 32'hF);
    check("async reset busy", 32'(busy_w), 32'h0);
    check("async reset byte_count", 32'(cnt_w[0]), 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    rbase = g_lane[0].rdn;
    v = '{0, 8'hA5, 40, 4, 1'b0, 1'b0};
    run_vec(v);
    check("post-reset byte_count", 32'(cnt_w[0]), 32'd1);
    check("post-reset rd pulses", g_lane[0].rdn, rbase + 1);

    // Random writes and tx_en toggling against the per-cycle lane models.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(0, 99) < 4);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 99) < 2) tx_en = ~tx_en;
    end
    @(negedge clk);
    wr_en = 1'b0;
    tx_en = 1'b1;
    drain(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
